// File: rtl/sprite_engine.sv
// sprite_engine: monochrome sprite hit generator for the 640x480 pixel path (2-cycle latency).
// Optional macro SPRITE_MIRROR_EN adds mirror_x_i, a frame-latched horizontal flip.
module sprite_engine #(
    parameter int SPR_W        = 16,
    parameter int SPR_H        = 19,
    parameter int SCALE_LOG2   = 0,
    parameter int BLINK_FRAMES = 30,
    parameter int X0           = 312,
    parameter int Y0           = 194
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [9:0]       x_i,
    input  logic [9:0]       y_i,
    input  logic             frame_tick_i,
    input  logic             pos_we_i,
    input  logic [9:0]       pos_x_i,
    input  logic [9:0]       pos_y_i,
    input  logic             bm_we_i,
    input  logic [4:0]       bm_row_i,
    input  logic [SPR_W-1:0] bm_data_i,
    input  logic             blink_en_i,
`ifdef SPRITE_MIRROR_EN
    input  logic             mirror_x_i,
`endif
    output logic             pixel_on_o
);
    localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [10:0] SPAN_X = 11'(SPR_W << SCALE_LOG2);
    localparam logic [10:0] SPAN_Y = 11'(SPR_H << SCALE_LOG2);

    logic [9:0]       act_x_q, act_x_d, act_y_q, act_y_d;
    logic [9:0]       pend_x_q, pend_x_d, pend_y_q, pend_y_d;
    logic [BW-1:0]    cnt_q, cnt_d;
    logic             vis_q, vis_d;
    logic             mir_q, mir_d;
    logic             in_q, in_d;
    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic             pix_q, pix_d;
    logic [SPR_W-1:0] bm_q [SPR_H];
    logic [10:0]      dx, dy;
    logic [CW-1:0]    bit_sel;
    logic             bm_wr;

    assign pixel_on_o = pix_q;

    // A tick copies the post-write pending value, so a same-cycle pos_we lands directly.
    always_comb begin
        pend_x_d = pend_x_q;
        pend_y_d = pend_y_q;
        act_x_d  = act_x_q;
        act_y_d  = act_y_q;
        if (pos_we_i) begin
            pend_x_d = pos_x_i;
            pend_y_d = pos_y_i;
        end
        if (frame_tick_i) begin
            act_x_d = pend_x_d;
            act_y_d = pend_y_d;
        end
    end

`ifdef SPRITE_MIRROR_EN
    assign mir_d = frame_tick_i ? mirror_x_i : mir_q;
`else
    assign mir_d = 1'b0;
`endif

    always_comb begin
        cnt_d = cnt_q;
        vis_d = vis_q;
        if (!blink_en_i) begin
            cnt_d = '0;
            vis_d = 1'b1;
        end else if (frame_tick_i) begin
            if (cnt_q == BW'(BLINK_FRAMES - 1)) begin
                cnt_d = '0;
                vis_d = ~vis_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Offsets are 11-bit two's complement; bit 10 set means the scan is left of / above the sprite.
    assign dx = {1'b0, x_i} - {1'b0, act_x_q};
    assign dy = {1'b0, y_i} - {1'b0, act_y_q};

    always_comb begin
        in_d    = (x_i < 10'd640) && (y_i < 10'd480) &&
                  !dx[10] && (dx < SPAN_X) && !dy[10] && (dy < SPAN_Y);
        col_d   = CW'(dx >> SCALE_LOG2);
        row_d   = RW'(dy >> SCALE_LOG2);
        bit_sel = mir_q ? col_q : CW'(SPR_W - 1) - col_q;
        pix_d   = in_q & bm_q[row_q][bit_sel] & vis_q;
        bm_wr   = bm_we_i && ({1'b0, bm_row_i} < 6'(SPR_H));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_x_q  <= 10'(X0);
            act_y_q  <= 10'(Y0);
            pend_x_q <= 10'(X0);
            pend_y_q <= 10'(Y0);
            cnt_q    <= '0;
            vis_q    <= 1'b1;
            mir_q    <= 1'b0;
            in_q     <= 1'b0;
            col_q    <= '0;
            row_q    <= '0;
            pix_q    <= 1'b0;
            for (int i = 0; i < SPR_H; i++) bm_q[i] <= '0;
        end else begin
            act_x_q  <= act_x_d;
            act_y_q  <= act_y_d;
            pend_x_q <= pend_x_d;
            pend_y_q <= pend_y_d;
            cnt_q    <= cnt_d;
            vis_q    <= vis_d;
            mir_q    <= mir_d;
            in_q     <= in_d;
            col_q    <= col_d;
            row_q    <= row_d;
            pix_q    <= pix_d;
            if (bm_wr) bm_q[RW'(bm_row_i)] <= bm_data_i;
        end
    end
endmodule
